seq_logic_unit: RTL and testbench
=================================

Name: seq_logic_unit

Overview:
Parametrised, multi-cycle bitwise logic unit. It is the successor to the team's fixed 32-bit single-function combinational logic blocks. Operands are captured once and processed SLICE bits per cycle under an 8-operation selector. Results are returned through a valid/ready handshake with a zero flag. The unit sits beside the ALU datapath as an area-reduced logic engine for wide operands.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE; SLICE == WIDTH is legal.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  operation select, sampled at accept
a  input  WIDTH  operand A, sampled at accept
b  input  WIDTH  operand B, sampled at accept
result  output  WIDTH  result register
zero  output  1  result == 0; meaningful while result_valid
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, slice counter = 0, result = 0, result_valid = 0, busy = 0, zero = 0.
  - start_ready is decoded from state, so it reads 1 during and after reset.
- Op encoding (op -> result slice):
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 PASSA (a).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - Accept edge = start_valid & start_ready. On it: capture a, b, op; clear result to 0 and the zero accumulator; counter = 0; go to RUN.
- RUN (SLICE bits per edge):
  - Each edge writes slice[counter] of result = f(op, a_slice, b_slice) into bits [counter*SLICE +: SLICE].
  - The same edge ORs that slice into the nonzero accumulator and increments the counter.
  - When counter == NSLICE-1, the same edge moves to DONE and the counter wraps to 0.
  - start_ready = 0. Input changes on a/b/op are ignored.
- DONE:
  - result_valid = 1. result and zero hold stable until result_ready is high at a clock edge.
  - That edge returns the FSM to IDLE and clears result_valid.
- Latency: result_valid rises exactly NSLICE cycles after the accept edge; NSLICE = 1 gives 1 cycle.
- Throughput: at most one request per NSLICE+2 cycles.
- start_ready is 0 in DONE, so a start_valid coinciding with result_ready is not accepted until the following IDLE cycle.
- zero = ~nonzero_accumulator, registered. It is valid only in DONE and is 0 elsewhere.
- busy = (state != IDLE).
- Reset mid-RUN or mid-DONE: abort immediately, no result_valid pulse, all outputs at reset values.
- result_valid never depends combinationally on result_ready; no combinational path from any input to any output except start_ready/busy from state.
- Elaboration check: WIDTH % SLICE != 0 or SLICE < 1 is a fatal elaboration error.

Decomposition:
- Package logic_unit_pkg:
  - 3-bit op localparams OP_AND … OP_PASSA.
  - FSM state encoding ST_IDLE/ST_RUN/ST_DONE.
  - Op width constant OP_W = 3.
- Sub-module logic_slice (parameter SLICE):
  - Purely combinational. Inputs op, a_s, b_s; output y_s.
  - Implements the 8 ops; instantiated once, with its inputs muxed by the slice counter.
- seq_logic_unit holds the FSM, counter, operand/result registers and handshake.

Test Plan:
- Reset then idle (WIDTH=32, SLICE=8): with rst_n low -> result=0, result_valid=0, busy=0, start_ready=1.
- NOR: op=011, a=0x0000_00FF, b=0x0F00_0000, result_ready=1 -> result_valid high 4 cycles after accept, result=0xF0FF_FF00, zero=0, back to IDLE next cycle.
- XOR then zero flag:
  - op=010, a=0xA5A5_A5A5, b=0xFFFF_FFFF -> 0x5A5A_5A5A, zero=0.
  - Then op=000, a=0xFFFF_0000, b=0x0000_FFFF -> 0x0000_0000, zero=1.
- Backpressure:
  - op=110, a=0xFFFF_FFFF, b=0x0F0F_0F0F, result_ready low 5 cycles -> result=0xF0F0_F0F0 and result_valid held stable.
  - start_valid asserted throughout is not accepted until after the handshake edge.
- Reset mid-RUN: assert rst_n low 2 cycles after accept -> result_valid never pulses, result=0; next request completes correctly.
- Parameter sweep: WIDTH=16, SLICE=16, op=101, a=0x1234, b=0x1234 -> result=0xFFFF after 1 cycle; WIDTH=64, SLICE=4 random ops vs. reference model, latency 16.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared constants for the sequential logic unit: op encodings and FSM states.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational 8-function bitwise slice; one instance serves every slice
// position, time-multiplexed by the owner's slice counter.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic [SLICE-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:   y_s = a_s & b_s;
      OP_OR:    y_s = a_s | b_s;
      OP_XOR:   y_s = a_s ^ b_s;
      OP_NOR:   y_s = ~(a_s | b_s);
      OP_NAND:  y_s = ~(a_s & b_s);
      OP_XNOR:  y_s = ~(a_s ^ b_s);
      OP_ANDN:  y_s = a_s & ~b_s;
      OP_PASSA: y_s = a_s;
      default:  y_s = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: captures operands once, processes SLICE bits
// per cycle, then presents the result and zero flag on a valid/ready handshake.
module seq_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  generate
    if (SLICE < 1) begin : g_bad_slice
      $fatal(1, "seq_logic_unit: SLICE must be at least 1");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $fatal(1, "seq_logic_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OP_W-1:0]  op_q;
  logic [CW-1:0]    cnt;
  logic             nonzero;
  logic [SLICE-1:0] a_s, b_s, y_s;
  logic             accept, last;

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = start_valid & start_ready;
  assign last        = (cnt == LAST);

  always_comb begin
    a_s = a_q[int'(cnt)*SLICE +: SLICE];
    b_s = b_q[int'(cnt)*SLICE +: SLICE];
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op  (op_q),
    .a_s (a_s),
    .b_s (b_s),
    .y_s (y_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept)       next_state = ST_RUN;
      ST_RUN:  if (last)         next_state = ST_DONE;
      ST_DONE: if (result_ready) next_state = ST_IDLE;
      default:                   next_state = ST_IDLE;
    endcase
  end

  // zero is computed on the final RUN edge from the accumulator plus the last slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt          <= '0;
      nonzero      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt     <= '0;
            nonzero <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
          end
        end
        ST_RUN: begin
          result[int'(cnt)*SLICE +: SLICE] <= y_s;
          nonzero <= nonzero | (|y_s);
          if (last) begin
            cnt          <= '0;
            result_valid <= 1'b1;
            zero         <= ~(nonzero | (|y_s));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            zero         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed scoreboard bench for seq_logic_unit across three WIDTH/SLICE sets.
module tb_seq_logic_unit;

  typedef struct {
    logic [63:0] res;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_valid;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        result_ready;

  logic        sr0, sr1, sr2, rv0, rv1, rv2, z0, z1, z2, bz0, bz1, bz2;
  logic [31:0] r0;
  logic [15:0] r1;
  logic [63:0] r2;

  logic [63:0] obs_result;
  logic        obs_ready, obs_valid, obs_zero, obs_busy;

  int   sel = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   passed = 0;
  int   fails = 0;
  int   total = 0;
  exp_t sb[$];
  int   wid[3] = '{32, 16, 64};
  int   ns[3]  = '{4, 1, 16};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_logic_unit #(.WIDTH(32), .SLICE(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid[0]), .start_ready(sr0),
    .op(op), .a(a[31:0]), .b(b[31:0]), .result(r0), .zero(z0),
    .result_valid(rv0), .result_ready(result_ready), .busy(bz0));

  seq_logic_unit #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid[1]), .start_ready(sr1),
    .op(op), .a(a[15:0]), .b(b[15:0]), .result(r1), .zero(z1),
    .result_valid(rv1), .result_ready(result_ready), .busy(bz1));

  seq_logic_unit #(.WIDTH(64), .SLICE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid[2]), .start_ready(sr2),
    .op(op), .a(a), .b(b), .result(r2), .zero(z2),
    .result_valid(rv2), .result_ready(result_ready), .busy(bz2));

  always_comb begin
    obs_result = {32'b0, r0};
    obs_ready  = sr0;
    obs_valid  = rv0;
    obs_zero   = z0;
    obs_busy   = bz0;
    case (sel)
      1: begin
        obs_result = {48'b0, r1}; obs_ready = sr1; obs_valid = rv1;
        obs_zero = z1; obs_busy = bz1;
      end
      2: begin
        obs_result = r2; obs_ready = sr2; obs_valid = rv2;
        obs_zero = z2; obs_busy = bz2;
      end
      default: ;
    endcase
  end

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y, input int w);
    logic [63:0] r, mask;
    case (o)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = x & ~y;
      default: r = x;
    endcase
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return r & mask;
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input logic [2:0] o, input logic [63:0] av, input logic [63:0] bv);
    exp_t e;
    e.res = ref_op(o, av, bv, wid[sel]);
    e.z   = (e.res == 64'd0);
    e.lat = ns[sel];
    sb.push_back(e);
  endtask

  // Drive one request and wait for its accept edge; unless held, the inputs are
  // then scrambled so a unit that failed to capture them produces a wrong result.
  task automatic applyStimulus(input logic [2:0] o, input logic [63:0] av,
                               input logic [63:0] bv, input bit hold);
    int waited;
    pushExpected(o, av, bv);
    @(negedge clk);
    op = o; a = av; b = bv;
    start_valid = 3'b000;
    start_valid[sel] = 1'b1;
    waited = 0;
    while (!obs_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check64("start_ready_at_request", {63'b0, obs_ready}, 64'd1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (!hold) begin
      start_valid = 3'b000;
      op = ~o; a = ~av; b = ~bv;
    end
  endtask

  task automatic checkOutput(input string tag, input bit drain);
    exp_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    @(negedge clk);
    while (!obs_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check64({tag, "_valid"},   {63'b0, obs_valid}, 64'd1);
    check64({tag, "_result"},  obs_result, e.res);
    check64({tag, "_zero"},    {63'b0, obs_zero}, {63'b0, e.z});
    check64({tag, "_latency"}, 64'(cyc - accept_cyc), 64'(e.lat));
    if (drain) begin
      @(posedge clk);
      #1;
      check64({tag, "_idle_valid"}, {63'b0, obs_valid}, 64'd0);
      check64({tag, "_idle_busy"},  {63'b0, obs_busy},  64'd0);
      check64({tag, "_idle_ready"}, {63'b0, obs_ready}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start_valid = 3'b000;
    op = 3'b000; a = '0; b = '0;
    result_ready = 1'b1;
    sel = 0;
    #3;
    check64("rst_result", obs_result, 64'd0);
    check64("rst_valid",  {63'b0, obs_valid}, 64'd0);
    check64("rst_busy",   {63'b0, obs_busy},  64'd0);
    check64("rst_ready",  {63'b0, obs_ready}, 64'd1);
    check64("rst_zero",   {63'b0, obs_zero},  64'd0);
    #9;
    rst_n = 1'b1;

    // NOR with busy/ready observed during RUN
    applyStimulus(3'b011, 64'h0000_00FF, 64'h0F00_0000, 1'b0);
    check64("nor_busy_run",  {63'b0, obs_busy},  64'd1);
    check64("nor_ready_run", {63'b0, obs_ready}, 64'd0);
    checkOutput("nor", 1'b1);

    applyStimulus(3'b010, 64'hA5A5_A5A5, 64'hFFFF_FFFF, 1'b0);
    checkOutput("xor", 1'b1);
    applyStimulus(3'b000, 64'hFFFF_0000, 64'h0000_FFFF, 1'b0);
    checkOutput("and_zero", 1'b1);

    // Backpressure with start_valid held high throughout
    result_ready = 1'b0;
    applyStimulus(3'b110, 64'hFFFF_FFFF, 64'h0F0F_0F0F, 1'b1);
    checkOutput("andn", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("bp_result", obs_result, 64'hF0F0_F0F0);
      check64("bp_valid",  {63'b0, obs_valid}, 64'd1);
      check64("bp_ready",  {63'b0, obs_ready}, 64'd0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check64("bp_hs_valid", {63'b0, obs_valid}, 64'd0);
    check64("bp_hs_ready", {63'b0, obs_ready}, 64'd1);
    check64("bp_hs_busy",  {63'b0, obs_busy},  64'd0);
    pushExpected(3'b110, 64'hFFFF_FFFF, 64'h0F0F_0F0F);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    start_valid = 3'b000;
    check64("bp_reaccept_busy", {63'b0, obs_busy}, 64'd1);
    checkOutput("andn_again", 1'b1);

    // Reset two cycles into RUN aborts the operation
    applyStimulus(3'b001, 64'h1234_5678, 64'h0F0F_0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check64("abort_result", obs_result, 64'd0);
    check64("abort_valid",  {63'b0, obs_valid}, 64'd0);
    check64("abort_busy",   {63'b0, obs_busy},  64'd0);
    check64("abort_ready",  {63'b0, obs_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check64("abort_no_valid", {63'b0, obs_valid}, 64'd0);
    end
    #2;
    rst_n = 1'b1;
    applyStimulus(3'b100, 64'hF0F0_F0F0, 64'hFFFF_0000, 1'b0);
    checkOutput("nand_after_abort", 1'b1);

    // Single-slice configuration
    sel = 1;
    applyStimulus(3'b101, 64'h1234, 64'h1234, 1'b0);
    checkOutput("xnor_w16", 1'b1);

    // Narrow slices on a wide operand, random ops
    sel = 2;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      checkOutput("rand_w64", 1'b1);
    end
    applyStimulus(3'b000, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0);
    checkOutput("zero_w64", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
